// File: rtl/mod241_chunk_accumulator_if.sv
// Chunk-residue stream in, frame residue result out, grouped as one bus.
// Latency: none (wires only).
// Backpressure: in_ready throttles the producer; out_ready throttles the result.
//
// Ports (master = upstream/consumer side, slave = accumulator):
//   in_valid/in_ready/in_residue/in_last     : one 8-bit chunk residue per handshake
//   out_valid/out_ready/out_residue          : frame sum mod MOD
//   out_range_err/out_len_err                : sticky per-frame error flags
interface mod241_chunk_accumulator_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_residue;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_residue;
    logic       out_range_err;
    logic       out_len_err;

    modport master (
        output in_valid,
        output in_residue,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_residue,
        input  out_range_err,
        input  out_len_err
    );

    modport slave (
        input  in_valid,
        input  in_residue,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_residue,
        output out_range_err,
        output out_len_err
    );
endinterface

// File: rtl/mod241_chunk_accumulator.sv
// Running mod-MOD sum of per-chunk residues over a frame; reports frame residue + error flags.
// Latency: one cycle per chunk; result valid the cycle after the last chunk is accepted.
// Backpressure: in_ready drops while a result waits for out_ready (one dead input cycle per frame).
//
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset, overrides any same-edge handshake
//   bus  : mod241_chunk_accumulator_if.slave (chunk input stream and frame result)
module mod241_chunk_accumulator #(
    parameter int MOD        = 241,
    parameter int NUM_CHUNKS = 84,
    parameter int CNT_W      = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    mod241_chunk_accumulator_if.slave     bus
);

    localparam logic [8:0]       MOD9    = 9'(MOD);
    localparam logic [7:0]       MOD8    = 8'(MOD);
    localparam logic [CNT_W:0]   NUM_CNT = (CNT_W+1)'(NUM_CHUNKS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             range_err_q, range_err_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_residue_q, out_residue_d;
    logic             out_range_err_q, out_range_err_d;
    logic             out_len_err_q, out_len_err_d;

    logic             in_ready;
    logic             in_fire;
    logic             out_fire;

    // Per-accept datapath values
    logic [7:0]       acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic             range_base;
    logic [8:0]       sum9;
    logic [8:0]       red1;
    logic [7:0]       acc_new;
    logic [CNT_W-1:0] cnt_new;
    logic [CNT_W:0]   cnt_plus1;
    logic             range_new;
    logic             len_err_new;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (in_fire) begin
                    state_d = bus.in_last ? ST_DONE : ST_ACC;
                end
            end
            ST_DONE: begin
                if (out_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (in_ready is a pure state decode, no input dependence)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = (state_q != ST_DONE);
        in_fire  = bus.in_valid & in_ready;
        out_fire = out_valid_q & bus.out_ready;
    end

    // ------------------------------------------------------------------
    // Accumulate datapath
    // ------------------------------------------------------------------
    always_comb begin
        // A frame's first chunk starts from zero regardless of what the
        // registers hold, so nothing from a previous frame can leak in.
        acc_base   = (state_q == ST_IDLE) ? 8'd0        : acc_q;
        cnt_base   = (state_q == ST_IDLE) ? '0          : cnt_q;
        range_base = (state_q == ST_IDLE) ? 1'b0        : range_err_q;

        // acc <= MOD-1 and residue <= 255, so sum9 <= 495 and two
        // conditional subtracts always land in [0, MOD-1].
        sum9    = {1'b0, acc_base} + {1'b0, bus.in_residue};
        red1    = (sum9 >= MOD9) ? (sum9 - MOD9) : sum9;
        acc_new = 8'((red1 >= MOD9) ? (red1 - MOD9) : red1);

        cnt_new     = (cnt_base == CNT_MAX) ? cnt_base : (cnt_base + CNT_W'(1));
        // One extra bit so a saturated count never aliases NUM_CHUNKS.
        cnt_plus1   = {1'b0, cnt_base} + (CNT_W+1)'(1);
        len_err_new = (cnt_plus1 != NUM_CNT);
        range_new   = range_base | (bus.in_residue >= MOD8);
    end

    // ------------------------------------------------------------------
    // Datapath / result next-state
    // ------------------------------------------------------------------
    always_comb begin
        acc_d           = acc_q;
        cnt_d           = cnt_q;
        range_err_d     = range_err_q;
        out_valid_d     = out_valid_q;
        out_residue_d   = out_residue_q;
        out_range_err_d = out_range_err_q;
        out_len_err_d   = out_len_err_q;

        if (in_fire) begin
            acc_d       = acc_new;
            cnt_d       = cnt_new;
            range_err_d = range_new;
            if (bus.in_last) begin
                out_valid_d     = 1'b1;
                out_residue_d   = acc_new;
                out_range_err_d = range_new;
                out_len_err_d   = len_err_new;
            end
        end

        // in_fire and out_fire never coincide: in_ready is low in DONE.
        // Result fields are left as last presented.
        if (out_fire) begin
            acc_d       = 8'd0;
            cnt_d       = '0;
            range_err_d = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q           <= 8'd0;
            cnt_q           <= '0;
            range_err_q     <= 1'b0;
            out_valid_q     <= 1'b0;
            out_residue_q   <= 8'd0;
            out_range_err_q <= 1'b0;
            out_len_err_q   <= 1'b0;
        end else begin
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
            range_err_q     <= range_err_d;
            out_valid_q     <= out_valid_d;
            out_residue_q   <= out_residue_d;
            out_range_err_q <= out_range_err_d;
            out_len_err_q   <= out_len_err_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_residue   = out_residue_q;
    assign bus.out_range_err = out_range_err_q;
    assign bus.out_len_err   = out_len_err_q;

endmodule

// File: tb/tb_mod241_chunk_accumulator.sv
// Bench for mod241_chunk_accumulator: directed frames with literal results plus
// randomized gapped frames, all checked every cycle against a frame-level model.
module tb_mod241_chunk_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mod241_chunk_accumulator_if bus ();

    mod241_chunk_accumulator #(
        .MOD        (241),
        .NUM_CHUNKS (84),
        .CNT_W      (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level reference model: the frame result is simply the plain
    // integer sum of all accepted residues taken mod 241; a result blocks
    // further input until it is taken.
    // ------------------------------------------------------------------
    int m_sum  = 0;
    int m_n    = 0;
    bit m_rerr = 0;
    bit m_ov   = 0;
    int e_res  = 0;
    bit e_rng  = 0;
    bit e_len  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_sum <= 0; m_n <= 0; m_rerr <= 0; m_ov <= 0;
            e_res <= 0; e_rng <= 0; e_len <= 0;
        end else if (m_ov) begin
            if (bus.out_ready) m_ov <= 0;
        end else if (bus.in_valid) begin
            if (bus.in_last) begin
                e_res  <= (m_sum + int'(bus.in_residue)) % 241;
                e_rng  <= m_rerr | (bus.in_residue >= 8'd241);
                e_len  <= ((m_n + 1) != 84);
                m_ov   <= 1;
                m_sum  <= 0; m_n <= 0; m_rerr <= 0;
            end else begin
                m_sum  <= m_sum + int'(bus.in_residue);
                m_n    <= m_n + 1;
                m_rerr <= m_rerr | (bus.in_residue >= 8'd241);
            end
        end
    end

    // Every-cycle compare, away from the active edge.
    always @(negedge clk) begin
        chk("m_in_ready",      32'(bus.in_ready),      32'(!m_ov));
        chk("m_out_valid",     32'(bus.out_valid),     32'(m_ov));
        chk("m_out_residue",   32'(bus.out_residue),   32'(e_res));
        chk("m_out_range_err", 32'(bus.out_range_err), 32'(e_rng));
        chk("m_out_len_err",   32'(bus.out_len_err),   32'(e_len));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic [7:0] fq[$];

    task automatic send_frame(input int gap_pct, input bit mark_last);
        int guard;
        for (int i = 0; i < fq.size(); i++) begin
            @(negedge clk);
            while (int'($urandom_range(99)) < gap_pct) begin
                bus.in_valid   = 1'b0;
                bus.in_residue = 8'($urandom);
                bus.in_last    = 1'($urandom);
                @(negedge clk);
            end
            bus.in_valid   = 1'b1;
            bus.in_residue = fq[i];
            bus.in_last    = mark_last && (i == fq.size() - 1);
            guard = 0;
            while (!bus.in_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            chk("accept_wait", 32'(guard < 200), 32'd1);
            @(posedge clk);
        end
    endtask

    task automatic wait_result(input int exp_res, input bit exp_rng, input bit exp_len,
                               input int hold, input bit offer);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < hold; k++) begin
            if (offer) begin
                bus.in_valid   = 1'b1;
                bus.in_residue = 8'd77;
                bus.in_last    = 1'b1;
            end
            @(negedge clk);
            chk("bp_in_ready",    32'(bus.in_ready),    32'd0);
            chk("bp_out_valid",   32'(bus.out_valid),   32'd1);
            chk("bp_out_residue", 32'(bus.out_residue), 32'(exp_res));
        end
        chk("res_residue",   32'(bus.out_residue),   32'(exp_res));
        chk("res_range_err", 32'(bus.out_range_err), 32'(exp_rng));
        chk("res_len_err",   32'(bus.out_len_err),   32'(exp_len));
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("release_in_ready",  32'(bus.in_ready),  32'd1);
    endtask

    task automatic ref_frame(output int r, output bit rg, output bit ln);
        int s = 0;
        rg = 1'b0;
        foreach (fq[i]) begin
            s += int'(fq[i]);
            if (fq[i] >= 8'd241) rg = 1'b1;
        end
        r  = s % 241;
        ln = (fq.size() != 84);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int r;
        bit rg, ln;
        int len;

        bus.in_valid   = 1'b0;
        bus.in_residue = 8'd0;
        bus.in_last    = 1'b0;
        bus.out_ready  = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_in_ready",  32'(bus.in_ready),    32'd1);
        chk("reset_out_valid", 32'(bus.out_valid),   32'd0);
        chk("reset_residue",   32'(bus.out_residue), 32'd0);
        rst = 1'b0;

        // Two-chunk wrap cases
        fq = '{8'd240, 8'd1};   send_frame(0, 1); wait_result(0,   0, 1, 0, 0);
        fq = '{8'd240, 8'd240}; send_frame(0, 1); wait_result(239, 0, 1, 0, 0);

        // Full-length frames, back to back
        fq.delete(); repeat (84) fq.push_back(8'd240);
        send_frame(0, 1); wait_result(157, 0, 0, 0, 0);
        fq.delete(); repeat (84) fq.push_back(8'd1);
        send_frame(0, 1); wait_result(84, 0, 0, 0, 0);

        // Out-of-range input, then flag clears on the next frame
        fq = '{8'd255}; send_frame(0, 1); wait_result(14, 1, 1, 0, 0);
        fq = '{8'd5};   send_frame(0, 1); wait_result(5,  0, 1, 0, 0);

        // Backpressure with an offered input that must not be consumed
        fq = '{8'd100, 8'd50}; send_frame(0, 1); wait_result(150, 0, 1, 5, 1);
        fq = '{8'd3};          send_frame(0, 1); wait_result(3,   0, 1, 0, 0);

        // Gapped 84-chunk frame of in-range random values
        fq.delete(); repeat (84) fq.push_back(8'($urandom_range(240)));
        ref_frame(r, rg, ln);
        send_frame(40, 1); wait_result(r, 0, 0, 0, 0);

        // Present a nonzero result, then abort a frame mid-way with reset
        fq = '{8'd9}; send_frame(0, 1); wait_result(9, 0, 1, 0, 0);
        fq.delete(); repeat (40) fq.push_back(8'($urandom_range(240)));
        send_frame(10, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", 32'(bus.out_valid),     32'd0);
        chk("midrst_in_ready",  32'(bus.in_ready),      32'd1);
        chk("midrst_residue",   32'(bus.out_residue),   32'd0);
        chk("midrst_range",     32'(bus.out_range_err), 32'd0);
        chk("midrst_len",       32'(bus.out_len_err),   32'd0);
        fq = '{8'd7, 8'd8}; send_frame(0, 1); wait_result(15, 0, 1, 0, 0);

        // Overlong frame: counter saturates, length error still flagged
        fq.delete(); repeat (130) fq.push_back(8'($urandom_range(240)));
        ref_frame(r, rg, ln);
        send_frame(5, 1); wait_result(r, 0, 1, 1, 0);

        // Randomized frames: lengths around NUM_CHUNKS, occasional out-of-range values
        for (int f = 0; f < 14; f++) begin
            fq.delete();
            len = (f % 3 == 0) ? 84 : int'($urandom_range(1, 90));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(99) < 8) fq.push_back(8'($urandom_range(241, 255)));
                else                        fq.push_back(8'($urandom_range(240)));
            end
            ref_frame(r, rg, ln);
            send_frame(int'($urandom_range(50)), 1);
            wait_result(r, rg, ln, int'($urandom_range(3)), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
